// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states
// and a small decode helper used by the handshake logic.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_LUI  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_ORI  = 4'd8;
  localparam logic [3:0] OP_SRAV = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  // True when the operation needs the iterative datapath; a zero divisor
  // short-circuits to a single-cycle result.
  function automatic logic is_seq_op(input logic [3:0] op, input logic divisor_zero);
    return (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && !divisor_zero);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: shift-add multiply (low WIDTH bits) and restoring
// unsigned divide/remainder, one step per clock for WIDTH clocks.
// The three working registers are shared between multiply and divide:
//   ra: accumulator / partial remainder
//   rb: multiplier / dividend shifting into quotient
//   rc: multiplicand / divisor
// busy drops combinationally during the final step so the owner can
// register result in that same cycle.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             run;
  logic             mul_mode;
  logic             rem_mode;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra, rb, rc;
  logic [WIDTH-1:0] ra_n, rb_n, rc_n;
  logic [WIDTH:0]   sh, df;
  logic             ge;
  logic             last;

  // One multiply or restoring-divide step from the current register state
  always_comb begin
    sh = {ra, rb[WIDTH-1]};
    df = sh - {1'b0, rc};
    ge = ~df[WIDTH];
    if (mul_mode) begin
      ra_n = ra + (rb[0] ? rc : '0);
      rb_n = rb >> 1;
      rc_n = rc << 1;
    end else begin
      ra_n = ge ? df[WIDTH-1:0] : sh[WIDTH-1:0];
      rb_n = {rb[WIDTH-2:0], ge};
      rc_n = rc;
    end
  end

  // Status and final-step result selection
  always_comb begin
    last   = (cnt == CW'(WIDTH - 1));
    busy   = run & ~last;
    result = (mul_mode | rem_mode) ? ra_n : rb_n;
  end

  // Operand load on start, then iterate until the last step completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      mul_mode <= 1'b0;
      rem_mode <= 1'b0;
      cnt      <= '0;
      ra       <= '0;
      rb       <= '0;
      rc       <= '0;
    end else if (start) begin
      run      <= 1'b1;
      mul_mode <= (op == OP_MUL);
      rem_mode <= (op == OP_REMU);
      cnt      <= '0;
      ra       <= '0;
      rb       <= (op == OP_MUL) ? src_b : src_a;
      rc       <= (op == OP_MUL) ? src_a : src_b;
    end else if (run) begin
      ra  <= ra_n;
      rb  <= rb_n;
      rc  <= rc_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU with start/done handshake. Single-cycle ops are
// computed here; MUL/DIVU/REMU iterate in alu_seq_muldiv.
// Optional build macro ALU_OVERFLOW_EN adds overflow_o (signed ADD/SUB).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
`ifdef ALU_OVERFLOW_EN
  , output logic           overflow_o
`endif
);

  localparam int HALF = WIDTH / 2;

  state_t           state, state_n;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             accept, md_start, md_busy;
  logic             load_alu, load_seq;
  logic [WIDTH-1:0] md_result;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_seq (
    .clk    (clk_i),
    .rst    (rst_i),
    .start  (md_start),
    .op     (ctrl_i),
    .src_a  (src1_i),
    .src_b  (src2_i),
    .busy   (md_busy),
    .result (md_result)
  );

  // Single-cycle result; also supplies the divide-by-zero results
  always_comb begin
    sum  = src1_i + src2_i;
    diff = src1_i - src2_i;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_NOR:  alu_res = ~(src1_i | src2_i);
      OP_LUI:  alu_res = {src2_i[HALF-1:0], {HALF{1'b0}}};
      OP_SRA:  alu_res = $signed(src2_i) >>> shamt_i;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      OP_ORI:  alu_res = {src1_i[WIDTH-1:HALF], src1_i[HALF-1:0] | src2_i[HALF-1:0]};
      OP_SRAV: alu_res = $signed(src2_i) >>> src1_i[SHW-1:0];
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = src1_i;
      default: alu_res = '0;
    endcase
  end

  // Handshake decode and result-register load strobes
  always_comb begin
    accept   = ready_o & start_i;
    md_start = accept & is_seq_op(ctrl_i, src2_i == '0);
    load_alu = accept & ~md_start;
    load_seq = ((state == S_MUL) || (state == S_DIV)) & ~md_busy;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (!start_i) begin
          state_n = S_IDLE;
        end else if (ctrl_i == OP_MUL) begin
          state_n = S_MUL;
        end else if (is_seq_op(ctrl_i, src2_i == '0)) begin
          state_n = S_DIV;
        end else begin
          state_n = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        if (!md_busy) begin
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_o = (state == S_IDLE) || (state == S_DONE);
    done_o  = (state == S_DONE);
  end

  // Result and zero flag, updated only on the edge that enters DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o <= '0;
      zero_o   <= 1'b0;
    end else if (load_alu) begin
      result_o <= alu_res;
      zero_o   <= (alu_res == '0);
    end else if (load_seq) begin
      result_o <= md_result;
      zero_o   <= (md_result == '0);
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic alu_ovf;

  // Signed overflow for ADD/SUB only
  always_comb begin
    case (ctrl_i)
      OP_ADD:  alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      OP_SUB:  alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end

  // Overflow flag registered alongside result_o
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (load_alu) begin
      overflow_o <= alu_ovf;
    end else if (load_seq) begin
      overflow_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): vector table, random
// ops against a reference model, and hand-written handshake sequences.
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    ctrl;
  logic [W-1:0]  src1, src2;
  logic [4:0]    shamt;
  logic          ready, done, zero;
  logic [W-1:0]  result;
`ifdef ALU_OVERFLOW_EN
  logic          ovf;
`endif

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .ctrl_i   (ctrl),
    .src1_i   (src1),
    .src2_i   (src2),
    .shamt_i  (shamt),
    .ready_o  (ready),
    .done_o   (done),
    .result_o (result),
    .zero_o   (zero)
`ifdef ALU_OVERFLOW_EN
    , .overflow_o (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   s;
    logic [W-1:0] e;
    logic         o;
  } vec_t;

  typedef struct {
    logic [W-1:0] e;
    logic         o;
    int           acc_cyc;
    int           lat;
    string        tag;
  } sb_t;

  sb_t  q[$];
  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   low_cnt = 0;
  int   prev_done = 0;
  int   last_done = 0;

  always @(posedge clk) cyc++;

  function automatic int exp_lat(input logic [3:0] c, input logic [W-1:0] b);
    return ((c == 4'd10) || (((c == 4'd11) || (c == 4'd13)) && (b != 0))) ? W + 1 : 1;
  endfunction

  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] s);
    logic [W-1:0] r;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd12: r = ~(a | b);
      4'd3:  r = {b[15:0], 16'h0000};
      4'd5:  r = $signed(b) >>> s;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = {a[31:16], a[15:0] | b[15:0]};
      4'd9:  r = $signed(b) >>> a[4:0];
      4'd10: r = a * b;
      4'd11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic model_ovf(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (c == 4'd2) begin
      r = a + b;
      return (a[31] == b[31]) && (r[31] != a[31]);
    end else if (c == 4'd6) begin
      r = a - b;
      return (a[31] != b[31]) && (r[31] != a[31]);
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Scoreboard: compare each done_o pulse with the oldest outstanding op
  always @(negedge clk) begin
    if (rst) begin
      low_cnt = 0;
    end else begin
      if (!ready) low_cnt++;
      if (done) begin
        prev_done = last_done;
        last_done = cyc;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done_o high with nothing outstanding, result %h", result);
        end else begin
          sb_t e;
          e = q.pop_front();
          check({e.tag, "_result"}, result, e.e);
          check({e.tag, "_zero"}, {31'b0, zero}, {31'b0, (e.e == 0)});
          check_int({e.tag, "_latency"}, cyc - e.acc_cyc + 1, e.lat);
          check_int({e.tag, "_ready_low"}, low_cnt, e.lat - 1);
`ifdef ALU_OVERFLOW_EN
          check({e.tag, "_ovf"}, {31'b0, ovf}, {31'b0, e.o});
`endif
        end
        low_cnt = 0;
      end
    end
  end

  // Called at a negedge: waits for ready, drives one start pulse, records expectation
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] s, input logic [W-1:0] e, input logic o, input string tag);
    int   g = 0;
    sb_t  ent;
    while (!ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: ready_o stayed 0, want 1", tag);
      return;
    end
    ctrl  = c;
    src1  = a;
    src2  = b;
    shamt = s;
    start = 1'b1;
    ent.e       = e;
    ent.o       = o;
    ent.acc_cyc = cyc + 1;
    ent.lat     = exp_lat(c, b);
    ent.tag     = tag;
    q.push_back(ent);
    @(negedge clk);
    start = 1'b0;
    ctrl  = 4'($urandom);
    src1  = $urandom;
    src2  = $urandom;
    shamt = 5'($urandom);
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_int({tag, "_outstanding"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] ops[13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    logic [3:0]   c;
    logic [W-1:0] a, b;
    logic [4:0]   s;

    //                c      a             b             s     expected      ovf
    tbl.push_back('{4'd2,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1});
    tbl.push_back('{4'd2,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0});
    tbl.push_back('{4'd6,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0});
    tbl.push_back('{4'd6,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1});
    tbl.push_back('{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0});
    tbl.push_back('{4'd1,  32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, 1'b0});
    tbl.push_back('{4'd12, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0});
    tbl.push_back('{4'd12, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  32'h00000000, 1'b0});
    tbl.push_back('{4'd3,  32'h12345678, 32'h9999ABCD, 5'd0,  32'hABCD0000, 1'b0});
    tbl.push_back('{4'd5,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0});
    tbl.push_back('{4'd5,  32'h00000000, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b0});
    tbl.push_back('{4'd5,  32'h00000000, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{4'd7,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0});
    tbl.push_back('{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0});
    tbl.push_back('{4'd7,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0});
    tbl.push_back('{4'd8,  32'h12345678, 32'hABCD00F0, 5'd0,  32'h123456F8, 1'b0});
    tbl.push_back('{4'd9,  32'h00000004, 32'h80000000, 5'd9,  32'hF8000000, 1'b0});
    tbl.push_back('{4'd9,  32'h00000023, 32'h80000000, 5'd0,  32'hF0000000, 1'b0});
    tbl.push_back('{4'd10, 32'hFFFFFFFF, 32'h00000003, 5'd0,  32'hFFFFFFFD, 1'b0});
    tbl.push_back('{4'd10, 32'h00010000, 32'h00010000, 5'd0,  32'h00000000, 1'b0});
    tbl.push_back('{4'd10, 32'h00001234, 32'h00010001, 5'd0,  32'h12341234, 1'b0});
    tbl.push_back('{4'd11, 32'd100,      32'd7,        5'd0,  32'd14,       1'b0});
    tbl.push_back('{4'd13, 32'd100,      32'd7,        5'd0,  32'd2,        1'b0});
    tbl.push_back('{4'd11, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0});
    tbl.push_back('{4'd11, 32'd7,        32'd100,      5'd0,  32'd0,        1'b0});
    tbl.push_back('{4'd13, 32'd7,        32'd100,      5'd0,  32'd7,        1'b0});
    tbl.push_back('{4'd11, 32'd5,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0});
    tbl.push_back('{4'd13, 32'd5,        32'd0,        5'd0,  32'd5,        1'b0});
    tbl.push_back('{4'd4,  32'hDEADBEEF, 32'h12345678, 5'd3,  32'h00000000, 1'b0});
    tbl.push_back('{4'd14, 32'hDEADBEEF, 32'h12345678, 5'd3,  32'h00000000, 1'b0});
    tbl.push_back('{4'd15, 32'hDEADBEEF, 32'h12345678, 5'd3,  32'h00000000, 1'b0});

    rst   = 1'b1;
    start = 1'b0;
    ctrl  = '0;
    src1  = '0;
    src2  = '0;
    shamt = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'd1);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", {31'b0, zero}, 32'd0);
`ifdef ALU_OVERFLOW_EN
    check("reset_ovf", {31'b0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Vector table, issued back-to-back wherever ready_o allows
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e, tbl[i].o, $sformatf("vec%0d", i));
    end
    drain("table");

    // DIVU then REMU accepted in DONE: second done exactly WIDTH+1 after first
    issue(4'd11, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, "b2b_divu");
    issue(4'd13, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0, "b2b_remu");
    drain("b2b");
    check_int("b2b_done_spacing", last_done - prev_done, W + 1);

    // start_i pulsed while MUL busy must be ignored (no extra done_o)
    issue(4'd10, 32'h00000007, 32'h00000009, 5'd0, 32'd63, 1'b0, "mul_ign");
    repeat (5) @(negedge clk);
    start = 1'b1;
    ctrl  = 4'd2;
    src1  = 32'd1;
    src2  = 32'd1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    drain("mul_ign");
    repeat (5) @(negedge clk);

    // Asynchronous reset during a MUL discards it
    issue(4'd10, 32'h00000011, 32'h00000003, 5'd0, 32'd51, 1'b0, "mul_rst");
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check("midrst_ready", {31'b0, ready}, 32'd1);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'b0, zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(4'd2, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, "post_rst_add");
    drain("post_rst");

    // Random operations against the reference model
    for (int i = 0; i < 16; i++) begin
      c = ops[$urandom_range(0, 12)];
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      s = 5'($urandom);
      issue(c, a, b, s, model(c, a, b, s), model_ovf(c, a, b), $sformatf("rnd%0d_op%0d", i, c));
    end
    drain("random");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the team's single-cycle ALU: same control encoding, generalised to WIDTH bits.
- Adds sequential multiply (shift-add) and unsigned divide/remainder (restoring), using a start/done handshake.
- Sits in the EX stage of the multi-cycle CPU. The control unit stalls on ready_o low and captures result_o on done_o.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; accepted only when ready_o=1
- ctrl_i  input  4  operation code (see Behaviour)
- src1_i  input  WIDTH  operand A / dividend / multiplicand
- src2_i  input  WIDTH  operand B / divisor / multiplier
- shamt_i  input  SHW  shift amount for SRA
- ready_o  output  1  block can accept start_i this cycle
- done_o  output  1  one-cycle pulse: result_o/zero_o valid
- result_o  output  WIDTH  registered result, held until next done_o
- zero_o  output  1  result_o == 0, registered with result_o

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset values:
  - state=IDLE, ready_o=1, done_o=0, result_o=0, zero_o=0.
  - All internal accumulators cleared.
- ctrl_i encoding:
  - 0 AND; 1 OR; 2 ADD; 6 SUB; 12 NOR.
  - 3 LUI: src2[WIDTH/2-1:0] into upper half, lower half 0.
  - 5 SRA: signed src2 >>> shamt_i.
  - 7 SLTU: unsigned src1<src2 gives 1, else 0.
  - 8 ORI: low half = src1|src2 low halves, upper half = src1 upper.
  - 9 SRAV: signed src2 >>> src1[SHW-1:0].
  - 10 MUL: low WIDTH bits of the product.
  - 11 DIVU: quotient.
  - 13 REMU: remainder.
  - 4, 14, 15: result 0, single-cycle.
- Arithmetic is modulo 2^WIDTH; no exceptions raised.
- State machine: IDLE, MUL, DIV, DONE.
  - IDLE/DONE with start_i=1:
    - single-cycle op: result computed and registered at the accepting edge; next state DONE.
    - op 10: operands latched, counter=0, next state MUL.
    - op 11/13 with src2!=0: operands latched, next state DIV.
    - op 11/13 with src2==0: result = all-ones (DIVU) or src1 (REMU); next state DONE.
  - IDLE/DONE with start_i=0: next state IDLE.
  - MUL: one multiplier bit per cycle; after WIDTH cycles, result registered, next state DONE.
  - DIV: one restoring step per cycle; after WIDTH cycles, quotient or remainder registered, next state DONE.
  - DONE: done_o=1 for exactly one cycle.
- ready_o=1 in IDLE and DONE; 0 in MUL and DIV. Back-to-back issue allowed: start_i in DONE is accepted.
- Latency, accepting edge to done_o high:
  - single-cycle ops and divide-by-zero: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles.
- start_i while ready_o=0: ignored. Operands and ctrl_i are don't-care after acceptance.
- result_o and zero_o change only on the cycle done_o rises; they hold otherwise.
- rst_i mid-operation: immediate return to IDLE, in-flight result discarded, no done_o.

Optional Feature:
- ALU_OVERFLOW_EN defined:
  - adds output overflow_o (1 bit, reset 0), registered with result_o.
  - 1 when ADD or SUB signed-overflows; 0 for all other ops.
- Not defined: port absent, no overflow logic.

Decomposition:
- Package alu_pkg holds:
  - 4-bit op localparams (OP_AND … OP_REMU).
  - state enum (S_IDLE, S_MUL, S_DIV, S_DONE).
- One sub-module, alu_seq_muldiv: holds the iterative multiply/divide datapath and counter. It exposes start/op/operands in and busy/result out.
- Single-cycle ops and the handshake FSM stay in alu_multicycle.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 1 -> done_o 1 cycle later; result 0x80000000, zero_o 0; overflow_o 1 when ALU_OVERFLOW_EN defined.
- MUL 0xFFFFFFFF * 3 -> ready_o low for 32 cycles, done_o at cycle 33, result 0xFFFFFFFD.
- DIVU 100/7 then REMU 100/7, issued back-to-back in DONE -> 14 then 2, each after 33 cycles, no idle gap.
- DIVU 5/0 -> result 0xFFFFFFFF after 1 cycle; REMU 5/0 -> 5.
- SRA src2=0x80000000, shamt 4 -> 0xF8000000; SUB 5-5 -> 0, zero_o 1; start_i pulsed during MUL -> ignored.
- Assert rst_i at cycle 10 of a MUL -> outputs return to reset values asynchronously; no done_o; next ADD 2+3 -> 5.
